// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile -- I2C target backed by a small byte-wide register file.
//
// A write transfer sets the register pointer and then writes data bytes at
// the pointer, which auto-increments. A read transfer returns bytes from the
// pointer, also auto-incrementing. The pointer wraps modulo MEM_DEPTH.
//
// Ports:
//   clk_i       system clock (>= 10x SCL frequency)
//   rst_i       asynchronous active-low reset
//   scl_i/sda_i bus levels
//   scl_o/sda_o open-drain drives (0 = pull low, 1 = release)
//   busy_o      set on an address match, cleared by STOP or a non-matching address
//   wr_pulse_o  one-cycle strobe per data byte written to the register file
//   wr_addr_o   register index of the last write
//   wr_data_o   byte of the last write
//
// Optional build macro I2C_SLAVE_STRETCH_EN: hold SCL low for STRETCH_CYCLES
// clocks after every ACK/NACK bit. Without it scl_o is tied high.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h22,
  parameter int         MEM_DEPTH      = 16,
  parameter int         PTR_W          = $clog2(MEM_DEPTH),
  parameter int         STRETCH_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o,
  output logic             busy_o,
  output logic             wr_pulse_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o
);

  if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      STRETCH_CYCLES < 1) begin : g_param_chk
    $error("i2c_slave_regfile: bad MEM_DEPTH or STRETCH_CYCLES");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t state, state_nxt;

  // ---- input conditioning: 2-flop sync + previous-value stage ----
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // ---- datapath state ----
  logic [MEM_DEPTH-1:0][7:0] mem;
  logic [PTR_W-1:0]          ptr;
  logic [3:0]                bit_cnt;   // bits shifted this byte; 8 = waiting for the ACK-slot fall
  logic [6:0]                rx_sh;
  logic [7:0]                tx_sh;
  logic                      rw;
  logic                      ack_seen;  // master ACKed the read byte; reload on next fall

  logic [7:0] byte_in;
  logic       last_bit, byte_done, shift_ok;
  assign byte_in   = {rx_sh, sda_s};
  assign last_bit  = (bit_cnt == 4'd7);
  assign byte_done = (bit_cnt == 4'd8);
  assign shift_ok  = scl_rise && !byte_done;

  // ---- FSM ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = ADDR;
    else if (stop_det) state_nxt = IDLE;
    else begin
      case (state)
        ADDR: begin
          if (shift_ok && last_bit && byte_in[7:1] != SLAVE_ADDR) state_nxt = IDLE;
          else if (scl_fall && byte_done)                         state_nxt = ADDR_ACK;
        end
        ADDR_ACK:  if (scl_fall) state_nxt = rw ? RDATA : PTR;
        PTR:       if (scl_fall && byte_done) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall) state_nxt = WDATA;
        WDATA:     if (scl_fall && byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nxt = WDATA;
        RDATA:     if (scl_fall && byte_done) state_nxt = RACK;
        RACK: begin
          if (scl_rise && sda_s)          state_nxt = IDLE;   // NACK: wait for START/STOP
          else if (scl_fall && ack_seen)  state_nxt = RDATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // ---- datapath ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem        <= '0;
      ptr        <= '0;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      rw         <= 1'b0;
      ack_seen   <= 1'b0;
      sda_o      <= 1'b1;
      busy_o     <= 1'b0;
      wr_pulse_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      wr_pulse_o <= 1'b0;
      if (start_det) begin
        bit_cnt <= '0;
        sda_o   <= 1'b1;
      end else if (stop_det) begin
        bit_cnt <= '0;
        sda_o   <= 1'b1;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (shift_ok) begin
              rx_sh   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                busy_o <= (byte_in[7:1] == SLAVE_ADDR);
                rw     <= byte_in[0];
              end
            end
            if (scl_fall && byte_done) sda_o <= 1'b0;
          end
          ADDR_ACK: if (scl_fall) begin
            if (rw) begin
              sda_o   <= mem[ptr][7];
              tx_sh   <= {mem[ptr][6:0], 1'b0};
              bit_cnt <= 4'd1;
            end else begin
              sda_o   <= 1'b1;
              bit_cnt <= '0;
            end
          end
          PTR: begin
            if (shift_ok) begin
              rx_sh   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) ptr <= byte_in[PTR_W-1:0];
            end
            if (scl_fall && byte_done) sda_o <= 1'b0;
          end
          WDATA: begin
            if (shift_ok) begin
              rx_sh   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                mem[ptr]   <= byte_in;
                wr_pulse_o <= 1'b1;
                wr_addr_o  <= ptr;
                wr_data_o  <= byte_in;
                ptr        <= ptr + PTR_W'(1);
              end
            end
            if (scl_fall && byte_done) sda_o <= 1'b0;
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            sda_o   <= 1'b1;
            bit_cnt <= '0;
          end
          RDATA: if (scl_fall) begin
            if (byte_done) begin
              sda_o    <= 1'b1;
              ack_seen <= 1'b0;
            end else begin
              sda_o   <= tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RACK: begin
            if (scl_rise) begin
              ptr      <= ptr + PTR_W'(1);
              ack_seen <= ~sda_s;
            end else if (scl_fall && ack_seen) begin
              // ptr already advanced on the ACK rise
              sda_o   <= mem[ptr][7];
              tx_sh   <= {mem[ptr][6:0], 1'b0};
              bit_cnt <= 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---- optional clock stretching ----
`ifdef I2C_SLAVE_STRETCH_EN
  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  logic [CNT_W-1:0] str_cnt;
  logic             nack_pend;  // NACK seen; stretch on the fall that ends it
  logic             stretch_go;

  assign stretch_go = scl_fall &&
                      ((state == ADDR_ACK) || (state == PTR_ACK) || (state == WDATA_ACK) ||
                       (state == RACK && ack_seen) || nack_pend);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      str_cnt   <= '0;
      nack_pend <= 1'b0;
    end else if (start_det || stop_det) begin
      str_cnt   <= '0;
      nack_pend <= 1'b0;
    end else begin
      if (stretch_go)          str_cnt <= CNT_W'(STRETCH_CYCLES);
      else if (str_cnt != '0)  str_cnt <= str_cnt - CNT_W'(1);
      if (state == RACK && scl_rise && sda_s) nack_pend <= 1'b1;
      else if (scl_fall)                      nack_pend <= 1'b0;
    end
  end

  assign scl_o = (str_cnt == '0);
`else
  assign scl_o = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
  localparam time Q = 100ns;  // quarter SCL period (10 clk cycles)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_o, sda_o, busy_o, wr_pulse_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic scl_bus, sda_bus;

  always #5 clk = ~clk;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  i2c_slave_regfile dut (
    .clk_i(clk), .rst_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .busy_o(busy_o), .wr_pulse_o(wr_pulse_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  int n_cmp = 0, n_err = 0;

  typedef struct { logic [7:0] val; int tag; } item_t;  // tag 0 = ack bit, 1 = read byte
  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  item_t exp_q[$], obs_q[$];
  wr_t   wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---- scoreboard monitor ----
  item_t mo, me;
  wr_t   mw;
  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_obs: got 0x%0h expected none", mo.val);
      end else begin
        me = exp_q.pop_front();
        chk(me.tag == 0 ? "ack_bit" : "read_byte", mo.val, me.val);
      end
    end
    if (wr_pulse_o === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none", wr_addr_o, wr_data_o);
      end else begin
        mw = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(mw.a));
        chk("wr_data", 32'(wr_data_o), 32'(mw.d));
      end
    end
  end

`ifdef I2C_SLAVE_STRETCH_EN
  int low_run = 0, n_stretch = 0;
  always @(negedge clk) begin
    if (scl_o === 1'b0) low_run++;
    else if (low_run != 0) begin
      chk("stretch_len", low_run, 8);
      n_stretch++;
      low_run = 0;
    end
  end
`else
  int scl_low_cnt = 0;
  always @(negedge clk) if (scl_o !== 1'b1) scl_low_cnt++;
`endif

  // ---- bus master ----
  task automatic wait_high();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (scl_bus) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL scl_timeout: got scl low expected release");
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; #Q;
    scl_m = 1'b1; wait_high(); #Q;
    s = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic start_c();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; wait_high(); #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; wait_high(); #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input logic exp_ack);
    logic s;
    exp_q.push_back('{val: {7'b0, exp_ack}, tag: 0});
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    obs_q.push_back('{val: {7'b0, s}, tag: 0});
  endtask

  task automatic rbyte(input logic [7:0] exp, input logic nack);
    logic s;
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      r = {r[6:0], s};
    end
    clk_bit(nack, s);
    exp_q.push_back('{val: exp, tag: 1});
    obs_q.push_back('{val: r, tag: 1});
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back('{a: a, d: d});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---- directed stimulus ----
  initial begin
    logic s;
    repeat (5) @(negedge clk);
    chk("rst_sda", sda_o, 1);
    chk("rst_scl", scl_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_wr_pulse", wr_pulse_o, 0);
    chk("rst_wr_addr", 32'(wr_addr_o), 0);
    chk("rst_wr_data", 32'(wr_data_o), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // write 0xA5, 0x5A starting at register 3
    start_c();
    wbyte(8'h44, 1'b0);
    chk("busy_after_match", busy_o, 1);
    wbyte(8'h03, 1'b0);
    expect_wr(4'd3, 8'hA5); wbyte(8'hA5, 1'b0);
    expect_wr(4'd4, 8'h5A); wbyte(8'h5A, 1'b0);
    stop_c();
    chk("busy_after_stop", busy_o, 0);

    // read back through a repeated START
    start_c();
    wbyte(8'h44, 1'b0);
    wbyte(8'h03, 1'b0);
    start_c();
    wbyte(8'h45, 1'b0);
    rbyte(8'hA5, 1'b0);
    rbyte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("sda_after_nack", sda_o, 1);
    stop_c();

    // pointer wrap 15 -> 0
    start_c();
    wbyte(8'h44, 1'b0);
    wbyte(8'h0F, 1'b0);
    expect_wr(4'd15, 8'h11); wbyte(8'h11, 1'b0);
    expect_wr(4'd0,  8'h22); wbyte(8'h22, 1'b0);
    stop_c();
    start_c();
    wbyte(8'h44, 1'b0); wbyte(8'h0F, 1'b0);
    start_c();
    wbyte(8'h45, 1'b0);
    rbyte(8'h11, 1'b0);
    rbyte(8'h22, 1'b1);
    stop_c();
    // pointer byte 0x13 selects register 3
    start_c();
    wbyte(8'h44, 1'b0); wbyte(8'h13, 1'b0);
    start_c();
    wbyte(8'h45, 1'b0);
    rbyte(8'hA5, 1'b1);
    stop_c();

    // address mismatch: no ACK, no busy, no writes
    start_c();
    wbyte(8'h46, 1'b1);
    chk("busy_mismatch", busy_o, 0);
    wbyte(8'h00, 1'b1);
    wbyte(8'h77, 1'b1);
    stop_c();

    // reset mid data byte
    start_c();
    wbyte(8'h44, 1'b0);
    wbyte(8'h05, 1'b0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    chk("busy_before_abort", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_sda", sda_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_scl", scl_o, 1);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    rst_n = 1'b1;
    #(2*Q);
    start_c();
    wbyte(8'h44, 1'b0); wbyte(8'h00, 1'b0);
    start_c();
    wbyte(8'h45, 1'b0);
    for (int i = 0; i < 16; i++) rbyte(8'h00, i == 15);
    stop_c();

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("exp_queue_drained", exp_q.size(), 0);
`ifdef I2C_SLAVE_STRETCH_EN
    chk("stretch_seen", 32'(n_stretch != 0), 1);
`else
    chk("scl_o_const_high", scl_low_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Synthesizable I2C target that sits downstream of the iicmb master on one bus of its `scl`/`sda` arrays.
- Consumes the START, address, data and STOP sequences the master produces, and answers with ACKs and read data.
- Backs a small byte-wide register file with an auto-incrementing pointer.
- Serves as an RTL responder for the I2C agent environment and as a reusable peripheral model.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit I2C address this target responds to.
- MEM_DEPTH, 16, number of byte registers; power of two, 2..256.
- PTR_W, $clog2(MEM_DEPTH), pointer width (derived, not overridden).
- STRETCH_CYCLES, 8, clk_i cycles SCL is held low per stretch (only with STRETCH_EN).

Ports:
- clk_i, input, 1, system clock; must be at least 10x the SCL frequency.
- rst_i, input, 1, asynchronous active-low reset.
- scl_i, input, 1, bus SCL level.
- sda_i, input, 1, bus SDA level.
- scl_o, output, 1, open-drain SCL drive; 0 = pull low, 1 = release.
- sda_o, output, 1, open-drain SDA drive; 0 = pull low, 1 = release.
- busy_o, output, 1, high from an address match until STOP or a non-matching address.
- wr_pulse_o, output, 1, one-cycle strobe when a data byte is written to memory.
- wr_addr_o, output, PTR_W, register index of the last write.
- wr_data_o, output, 8, byte of the last write.

Behaviour:
- Reset (rst_i low, asynchronous): sda_o=1, scl_o=1, busy_o=0, wr_pulse_o=0, wr_addr_o=0, wr_data_o=0, pointer=0, all memory bytes=0, state=IDLE. Reset mid-transfer releases SDA immediately.
- Input conditioning: scl_i and sda_i pass through a 2-flop synchronizer, then a registered previous-value stage. Detected events lag the bus by 3 cycles.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - rise/fall: SCL edges.
- Bits are sampled MSB first on SCL rise. sda_o changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- START from any state, including a repeated start: go to ADDR and clear the bit counter. sda_o=1, except in RDATA, where SDA is released on the START.
- STOP from any state: go to IDLE, sda_o=1, busy_o=0. Pointer and memory are retained.
- ADDR: shift 8 bits.
  - Bits[7:1]==SLAVE_ADDR: set busy_o. On the next SCL fall drive sda_o=0 (ACK) and enter ADDR_ACK.
  - Mismatch: go to IDLE with no ACK; ignore the bus until the next START.
- ADDR_ACK: on the next SCL fall release SDA.
  - R/W=0: go to PTR.
  - R/W=1: load mem[ptr], drive its MSB in the same fall, go to RDATA.
- PTR: shift 8 bits. pointer = byte mod MEM_DEPTH. ACK as above via PTR_ACK, then go to WDATA.
- WDATA: shift 8 bits, then ACK via WDATA_ACK.
  - The write occurs on the cycle the 8th bit is sampled: mem[ptr]=byte, wr_addr_o=ptr, wr_data_o=byte, one-cycle wr_pulse_o.
  - ptr increments, wrapping MEM_DEPTH-1 -> 0.
- RDATA: present bits on SCL falls. After the 8th bit, release SDA on the next fall and go to RACK.
- RACK: sample SDA on SCL rise.
  - 0 (ACK): ptr++ with wrap, load the next byte, drive its MSB on the next fall, go to RDATA.
  - 1 (NACK): ptr++ and go to IDLE-wait. SDA stays released until START/STOP.
- Byte count is unbounded; only the pointer wraps.
- A STOP or START mid-byte aborts the byte. A partial write byte is not written.
- A simultaneous START and SCL edge in the same cycle: START wins.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- When defined: after each ACK/NACK bit, on the SCL fall that ends it, scl_o=0 for STRETCH_CYCLES clk_i cycles, then scl_o=1.
  - The next data bit is set up on sda_o during the stretch.
  - STOP, START and reset each force scl_o=1 immediately.
- When undefined: scl_o is constant 1 and no stretch logic is synthesized.

Test Plan:
- Write: START, 0x44, ptr 0x03, data 0xA5, 0x5A, STOP -> three ACKs on the data phase; wr_pulse_o twice with (3,0xA5) then (4,0x5A); busy_o drops after STOP.
- Read: START, 0x44, ptr 0x03, repeated START, 0x45, read 2 bytes with ACK then NACK -> bus returns 0xA5, 0x5A; SDA is released after NACK.
- Wrap: ptr 0x0F, write 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22. A ptr byte of 0x13 selects register 3.
- Mismatch: START, 0x46 -> no ACK (SDA stays 1 at the 9th clock), busy_o=0, no wr_pulse_o for the following bytes.
- Abort: reset asserted after 4 bits of a data byte -> sda_o=1 and busy_o=0 immediately; all memory reads back 0x00.
- Stretch (I2C_SLAVE_STRETCH_EN, STRETCH_CYCLES=8): after an address ACK, scl_o is low for exactly 8 clk_i cycles. Without the macro, scl_o stays 1 throughout.
